pipeline_hazard_ctrl: RTL and testbench

//  Central hazard/sequencing controller for the 5-stage integer pipeline.
//  - Detects load-use hazards and inserts one bubble.
//  - Sequences the multi-cycle divider in EX: start pulse, hold pipeline until done.
//  - Flushes wrong-path instructions on taken branch/jump.
//  - Drives EX operand forwarding selects.
//  - Sits beside the IF/ID/EX stages; its stall/flush outputs gate the PC and pipe registers.

---
 rtl/pipeline_hazard_ctrl.sv | 157 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage integer pipeline: load-use bubbles,
// multi-cycle divider handshake, taken-branch flush and EX operand forwarding selects.
module pipeline_hazard_ctrl #(
    parameter int unsigned DIV_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rs1_addr,
    input  logic [4:0]       ex_rs2_addr,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_is_load,
    input  logic             ex_div_instr,
    input  logic             ex_branch_taken,
    input  logic             div_busy,
    input  logic [4:0]       mem_rd_addr,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd_addr,
    input  logic             wb_reg_write,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             flush_id,
    output logic             div_start,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned   TO_W    = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(DIV_TIMEOUT - 1);

    typedef enum logic [1:0] {StRun, StDivWait, StDivDone} state_e;

    state_e           state_q, state_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic             busy_seen_q, busy_seen_d;
    logic [CNT_W-1:0] stall_count_q;
    logic             load_use;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] mem_rd, input logic mem_we,
                                           input logic [4:0] wb_rd, input logic wb_we);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0 && mem_we && mem_rd == rs) begin
            sel = 2'b01;
        end else if (rs != 5'd0 && wb_we && wb_rd == rs) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        load_use = ex_is_load && (ex_rd_addr != 5'd0) &&
                   ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                    (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    end

    always_comb begin
        state_d     = state_q;
        to_d        = to_q;
        busy_seen_d = busy_seen_q;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        bubble_ex   = 1'b0;
        flush_id    = 1'b0;
        div_start   = 1'b0;
        fwd_a_sel   = fwd_sel(ex_rs1_addr, mem_rd_addr, mem_reg_write, wb_rd_addr, wb_reg_write);
        fwd_b_sel   = fwd_sel(ex_rs2_addr, mem_rd_addr, mem_reg_write, wb_rd_addr, wb_reg_write);

        unique case (state_q)
            StRun: begin
                if (ex_branch_taken) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end else if (ex_div_instr) begin
                    div_start   = 1'b1;
                    stall_if    = 1'b1;
                    stall_id    = 1'b1;
                    stall_ex    = 1'b1;
                    state_d     = StDivWait;
                    to_d        = '0;
                    busy_seen_d = 1'b0;
                end else if (load_use) begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
            end
            StDivWait: begin
                stall_if = 1'b1;
                stall_id = 1'b1;
                stall_ex = 1'b1;
                // Done once busy has gone high and come back low; timeout is a safety net.
                if ((busy_seen_q && !div_busy) || to_q == TO_LAST) begin
                    state_d = StDivDone;
                end else begin
                    to_d = to_q + TO_W'(1);
                    if (div_busy) begin
                        busy_seen_d = 1'b1;
                    end
                end
            end
            StDivDone: begin
                if (ex_branch_taken) begin
                    flush_id  = 1'b1;
                    bubble_ex = 1'b1;
                end
                state_d = StRun;
            end
            default: begin
                state_d = StRun;
            end
        endcase

        if (reset) begin
            stall_if  = 1'b0;
            stall_id  = 1'b0;
            stall_ex  = 1'b0;
            bubble_ex = 1'b0;
            flush_id  = 1'b0;
            div_start = 1'b0;
            fwd_a_sel = 2'b00;
            fwd_b_sel = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            to_q        <= '0;
            busy_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            to_q        <= to_d;
            busy_seen_q <= busy_seen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if (stall_if && stall_count_q != '1) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a driver pushes model expectations per cycle,
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned DIV_TIMEOUT = 64;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       reset;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       u1;
        logic       u2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ld;
        logic       div;
        logic       br;
        logic       busy;
        logic [4:0] mem_rd;
        logic       mw;
        logic [4:0] wb_rd;
        logic       ww;
    } stim_t;

    typedef struct packed {
        logic [9:0]       ctrl;  // {stall_if,stall_id,stall_ex,bubble_ex,flush_id,div_start,a,b}
        logic [CNT_W-1:0] count;
    } exp_t;

    logic clk;
    logic reset;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [4:0] mem_rd_addr, wb_rd_addr;
    logic id_uses_rs1, id_uses_rs2, ex_is_load, ex_div_instr, ex_branch_taken, div_busy;
    logic mem_reg_write, wb_reg_write;
    logic stall_if, stall_id, stall_ex, bubble_ex, flush_id, div_start;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [CNT_W-1:0] stall_count;

    pipeline_hazard_ctrl #(
        .DIV_TIMEOUT(DIV_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1_addr    (id_rs1_addr),
        .id_rs2_addr    (id_rs2_addr),
        .id_uses_rs1    (id_uses_rs1),
        .id_uses_rs2    (id_uses_rs2),
        .ex_rs1_addr    (ex_rs1_addr),
        .ex_rs2_addr    (ex_rs2_addr),
        .ex_rd_addr     (ex_rd_addr),
        .ex_is_load     (ex_is_load),
        .ex_div_instr   (ex_div_instr),
        .ex_branch_taken(ex_branch_taken),
        .div_busy       (div_busy),
        .mem_rd_addr    (mem_rd_addr),
        .mem_reg_write  (mem_reg_write),
        .wb_rd_addr     (wb_rd_addr),
        .wb_reg_write   (wb_reg_write),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .stall_ex       (stall_ex),
        .bubble_ex      (bubble_ex),
        .flush_id       (flush_id),
        .div_start      (div_start),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .stall_count    (stall_count)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    // Reference model: what the pipeline is doing, not how the controller encodes it.
    bit dividing;       // between the start pulse and the divider result
    bit result_cycle;   // the single cycle the result is taken downstream
    int wait_cycles;    // cycles already spent waiting on the divider
    bit busy_was_seen;
    int stalls;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [4:0] rs, input stim_t s);
        if (rs != 0 && s.mw && s.mem_rd == rs) return 2'b01;
        if (rs != 0 && s.ww && s.wb_rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    task automatic apply(input stim_t s);
        bit sif, sid, sex, bub, fl, st, lu;
        exp_t e;
        reset           = s.reset;
        id_rs1_addr     = s.id_rs1;
        id_rs2_addr     = s.id_rs2;
        id_uses_rs1     = s.u1;
        id_uses_rs2     = s.u2;
        ex_rs1_addr     = s.ex_rs1;
        ex_rs2_addr     = s.ex_rs2;
        ex_rd_addr      = s.ex_rd;
        ex_is_load      = s.ld;
        ex_div_instr    = s.div;
        ex_branch_taken = s.br;
        div_busy        = s.busy;
        mem_rd_addr     = s.mem_rd;
        mem_reg_write   = s.mw;
        wb_rd_addr      = s.wb_rd;
        wb_reg_write    = s.ww;

        {sif, sid, sex, bub, fl, st} = '0;
        lu = s.ld && s.ex_rd != 0 && ((s.u1 && s.id_rs1 == s.ex_rd) ||
                                      (s.u2 && s.id_rs2 == s.ex_rd));
        e.ctrl = '0;
        if (!s.reset) begin
            if (dividing) begin
                {sif, sid, sex} = 3'b111;
            end else if (s.br) begin
                {fl, bub} = 2'b11;
            end else if (s.div && !result_cycle) begin
                {st, sif, sid, sex} = 4'b1111;
            end else if (lu && !result_cycle) begin
                {sif, sid, bub} = 3'b111;
            end
            e.ctrl = {sif, sid, sex, bub, fl, st, fwd_exp(s.ex_rs1, s), fwd_exp(s.ex_rs2, s)};
        end
        e.count = CNT_W'(stalls);
        exp_q.push_back(e);

        if (s.reset) begin
            dividing = 0; result_cycle = 0; wait_cycles = 0; busy_was_seen = 0; stalls = 0;
        end else begin
            if (sif && stalls < CNT_MAX) stalls++;
            if (dividing) begin
                if ((busy_was_seen && !s.busy) || wait_cycles == DIV_TIMEOUT - 1) begin
                    dividing = 0;
                    result_cycle = 1;
                end else begin
                    wait_cycles++;
                    if (s.busy) busy_was_seen = 1;
                end
            end else if (result_cycle) begin
                result_cycle = 0;
            end else if (st) begin
                dividing = 1; wait_cycles = 0; busy_was_seen = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: this controller presents a response every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cycle++;
                checks++;
                if ({stall_if, stall_id, stall_ex, bubble_ex, flush_id, div_start,
                     fwd_a_sel, fwd_b_sel} !== e.ctrl) begin
                    errors++;
                    $display("FAIL ctrl cycle %0d: got %b expected %b", cycle,
                             {stall_if, stall_id, stall_ex, bubble_ex, flush_id, div_start,
                              fwd_a_sel, fwd_b_sel}, e.ctrl);
                end
                checks++;
                if (stall_count !== e.count) begin
                    errors++;
                    $display("FAIL stall_count cycle %0d: got %0d expected %0d", cycle,
                             stall_count, e.count);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        dividing = 0; result_cycle = 0; wait_cycles = 0; busy_was_seen = 0; stalls = 0;
        s = idle();
        s.reset = 1;
        reset = 1;
        {id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr} = '0;
        {mem_rd_addr, wb_rd_addr, id_uses_rs1, id_uses_rs2, ex_is_load} = '0;
        {ex_div_instr, ex_branch_taken, div_busy, mem_reg_write, wb_reg_write} = '0;
        repeat (2) @(posedge clk);
        #1;
        apply(s);

        // Load-use on rs1, then cleared; rd=x0 never stalls; rs2 path.
        s = idle(); s.ld = 1; s.ex_rd = 5; s.id_rs1 = 5; s.u1 = 1; apply(s);
        s = idle(); apply(s);
        s = idle(); s.ld = 1; s.ex_rd = 0; s.id_rs1 = 0; s.u1 = 1; apply(s);
        s = idle(); s.ld = 1; s.ex_rd = 9; s.id_rs2 = 9; s.u2 = 1; apply(s);
        s.u2 = 0; apply(s);

        // Divide with busy high for 3 cycles; DIV stays in EX through the result cycle.
        s = idle(); s.div = 1; apply(s);
        s.busy = 1; repeat (3) apply(s);
        s.busy = 0; repeat (2) apply(s);
        s.div = 0; apply(s);

        // Taken branch with a simultaneous load-use hazard.
        s = idle(); s.br = 1; s.ld = 1; s.ex_rd = 5; s.id_rs1 = 5; s.u1 = 1; apply(s);

        // Forwarding priority and x0.
        s = idle(); s.mem_rd = 7; s.wb_rd = 7; s.ex_rs1 = 7; s.ex_rs2 = 7; s.mw = 1; s.ww = 1;
        apply(s);
        s.mw = 0; apply(s);
        s.ex_rs1 = 0; apply(s);
        s.ex_rs2 = 3; s.mem_rd = 3; s.mw = 1; apply(s);

        // Divider never goes busy: forced exit.
        s = idle(); s.div = 1; apply(s);
        s.div = 0; repeat (DIV_TIMEOUT + 4) apply(s);

        // Reset in the middle of a divide, then DIV still present.
        s = idle(); s.div = 1; apply(s);
        s.busy = 1; repeat (2) apply(s);
        s.reset = 1; apply(s);
        s.reset = 0; s.busy = 0; apply(s);
        s.div = 0; repeat (2) apply(s);

        // Saturation of the stall counter under a held hazard.
        s = idle(); s.reset = 1; apply(s);
        s = idle(); s.ld = 1; s.ex_rd = 4; s.id_rs1 = 4; s.u1 = 1;
        repeat (CNT_MAX + 20) apply(s);
        s = idle(); s.reset = 1; apply(s);

        // Randomised traffic on a narrow register range to provoke hazards.
        for (int i = 0; i < 4000; i++) begin
            s.reset  = ($urandom_range(0, 199) == 0);
            s.id_rs1 = 5'($urandom_range(0, 3));
            s.id_rs2 = 5'($urandom_range(0, 3));
            s.u1     = 1'($urandom_range(0, 1));
            s.u2     = 1'($urandom_range(0, 1));
            s.ex_rs1 = 5'($urandom_range(0, 3));
            s.ex_rs2 = 5'($urandom_range(0, 3));
            s.ex_rd  = 5'($urandom_range(0, 3));
            s.ld     = ($urandom_range(0, 2) == 0);
            s.div    = ($urandom_range(0, 7) == 0);
            s.br     = ($urandom_range(0, 5) == 0);
            s.busy   = 1'($urandom_range(0, 1));
            s.mem_rd = 5'($urandom_range(0, 3));
            s.mw     = 1'($urandom_range(0, 1));
            s.wb_rd  = 5'($urandom_range(0, 3));
            s.ww     = 1'($urandom_range(0, 1));
            apply(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
